// File: rtl/reflex_pkg.sv
// Shared definitions for the reaction-game control path.
//   state_e   : game FSM encoding (IDLE, DELAY, SHOW, DONE)
//   H_ACTIVE  : visible line width in pixels
//   V_ACTIVE  : visible frame height in lines
//   LFSR_TAPS : feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
package reflex_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_SHOW  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned H_ACTIVE  = 640;
   localparam int unsigned V_ACTIVE  = 480;

   // Bits 0,2,3,5 XORed feed bit 15 of the right-shifting register.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads SEED (must be nonzero)
//   value : current register contents, advances every clock out of reset
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] value
);
   import reflex_pkg::*;

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value = lfsr_q;

endmodule

// File: rtl/target_spawner.sv
// Reaction-game control: picks pseudo-random target position and pre-show
// delay, shows the target, times the player's reaction and keeps score.
//   clk, rst_n        : 25 MHz pixel clock, asynchronous active-low reset
//   game_en           : level, high while a game runs (rising edge starts one)
//   press, on_target  : single-cycle press and cursor-over-target qualifier
//   ballX, ballY      : target top-left corner for the display stage
//   start             : target visible
//   hit_count, miss_count, last_rt_ms, game_over : score outputs
module target_spawner #(
   parameter int unsigned TICK_DIV     = 25000,
   parameter int unsigned BALL_SIZE    = 40,
   parameter int unsigned DELAY_MIN_MS = 500,
   parameter int unsigned TIMEOUT_MS   = 1000,
   parameter int unsigned ROUNDS       = 10,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       game_en,
   input  logic       press,
   input  logic       on_target,
   output logic [9:0] ballX,
   output logic [9:0] ballY,
   output logic       start,
   output logic [7:0] hit_count,
   output logic [7:0] miss_count,
   output logic [9:0] last_rt_ms,
   output logic       game_over
);
   import reflex_pkg::*;

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // One counter serves as ms counter in DELAY and reaction counter in SHOW.
   localparam int unsigned CNT_W = 16;

   localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
   localparam logic [9:0]       X_LIM       = 10'(H_ACTIVE - BALL_SIZE);
   localparam logic [8:0]       Y_LIM       = 9'(V_ACTIVE - BALL_SIZE);
   localparam logic [CNT_W-1:0] DELAY_MIN_C = CNT_W'(DELAY_MIN_MS);
   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT_MS);
   localparam logic [7:0]       ROUNDS_C    = 8'(ROUNDS);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_e           state_q,   state_d;
   logic [PRE_W-1:0] presc_q,   presc_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [CNT_W-1:0] delay_q,   delay_d;
   logic [7:0]       round_q,   round_d;
   logic [9:0]       ballx_q,   ballx_d;
   logic [9:0]       bally_q,   bally_d;
   logic [7:0]       hit_q,     hit_d;
   logic [7:0]       miss_q,    miss_d;
   logic [9:0]       last_rt_q, last_rt_d;
   logic             start_q,   start_d;
   logic             over_q,    over_d;
   logic             game_en_q, game_en_d;

   logic [15:0]      lfsr;
   logic             tick;
   logic [CNT_W-1:0] cnt_inc;
   logic [9:0]       pos_x;
   logic [8:0]       raw_y;
   logic [9:0]       pos_y;
   logic [CNT_W-1:0] new_delay;
   logic [9:0]       rt_sat;
   logic             enter_delay;
   logic             round_end;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .value (lfsr)
   );

   assign tick      = (presc_q == PRE_LAST);
   assign cnt_inc   = (tick && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   assign pos_x     = (lfsr[9:0] >= X_LIM) ? lfsr[9:0] - X_LIM : lfsr[9:0];
   assign raw_y     = {lfsr[15:10], lfsr[2:0]};
   assign pos_y     = {1'b0, ((raw_y >= Y_LIM) ? raw_y - Y_LIM : raw_y)};
   assign new_delay = DELAY_MIN_C + CNT_W'(lfsr[12:3]);
   assign rt_sat    = (|cnt_q[CNT_W-1:10]) ? '1 : cnt_q[9:0];

   always_comb begin
      state_d     = state_q;
      presc_d     = tick ? '0 : presc_q + PRE_W'(1);
      cnt_d       = cnt_inc;
      delay_d     = delay_q;
      round_d     = round_q;
      ballx_d     = ballx_q;
      bally_d     = bally_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      last_rt_d   = last_rt_q;
      over_d      = over_q;
      game_en_d   = game_en;
      enter_delay = 1'b0;
      round_end   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (game_en && !game_en_q) begin
               hit_d       = '0;
               miss_d      = '0;
               last_rt_d   = '0;
               over_d      = 1'b0;
               round_d     = '0;
               enter_delay = 1'b1;
            end
         end
         ST_DELAY: begin
            // Abort beats everything; a press beats an expiring delay.
            if (!game_en) begin
               state_d = ST_IDLE;
            end else if (press) begin
               miss_d    = sat_inc8(miss_q);
               round_end = 1'b1;
            end else if (cnt_inc == delay_q) begin
               state_d = ST_SHOW;
            end
         end
         ST_SHOW: begin
            // A press in the timeout cycle is scored as the press only.
            if (!game_en) begin
               state_d = ST_IDLE;
            end else if (press) begin
               if (on_target) begin
                  hit_d     = sat_inc8(hit_q);
                  last_rt_d = rt_sat;
               end else begin
                  miss_d = sat_inc8(miss_q);
               end
               round_end = 1'b1;
            end else if (cnt_inc == TIMEOUT_C) begin
               miss_d    = sat_inc8(miss_q);
               round_end = 1'b1;
            end
         end
         ST_DONE: begin
            if (!game_en) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (round_end) begin
         round_d = sat_inc8(round_q);
         if (round_d == ROUNDS_C) begin
            state_d = ST_DONE;
            over_d  = 1'b1;
         end else begin
            enter_delay = 1'b1;
         end
      end

      if (enter_delay) begin
         state_d = ST_DELAY;
         ballx_d = pos_x;
         bally_d = pos_y;
         delay_d = new_delay;
      end

      // DELAY re-entry keeps state_d == state_q, hence the explicit flag.
      if (enter_delay || (state_d != state_q)) begin
         presc_d = '0;
         cnt_d   = '0;
      end

      start_d = (state_d == ST_SHOW);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         cnt_q     <= '0;
         delay_q   <= '0;
         round_q   <= '0;
         ballx_q   <= '0;
         bally_q   <= '0;
         hit_q     <= '0;
         miss_q    <= '0;
         last_rt_q <= '0;
         start_q   <= 1'b0;
         over_q    <= 1'b0;
         game_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         delay_q   <= delay_d;
         round_q   <= round_d;
         ballx_q   <= ballx_d;
         bally_q   <= bally_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         last_rt_q <= last_rt_d;
         start_q   <= start_d;
         over_q    <= over_d;
         game_en_q <= game_en_d;
      end
   end

   assign ballX      = ballx_q;
   assign ballY      = bally_q;
   assign start      = start_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
   assign last_rt_ms = last_rt_q;
   assign game_over  = over_q;

endmodule
